// File: rtl/uart_os_pkg.sv
// Shared types, sampling constants and helpers for the oversampling UART receiver.
package uart_os_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int          OVERSAMPLE = 16;
  localparam logic [3:0]  VOTE_LO    = 4'd7;
  localparam logic [3:0]  VOTE_MID   = 4'd8;
  localparam logic [3:0]  VOTE_HI    = 4'd9;
  localparam logic [3:0]  BIT_END    = 4'd15;
  localparam int          DATA_MAX   = 9;

  typedef struct packed {
    logic                brk;
    logic                ferr;
    logic                perr;
    logic [DATA_MAX-1:0] data;
  } rx_entry_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Zero-extended data bits do not change the reduction, so any width up to DATA_MAX works.
  function automatic logic parity_mismatch(input logic [DATA_MAX-1:0] d,
                                           input logic pbit, input logic odd);
    return ((^d) ^ pbit) != odd;
  endfunction

endpackage

// File: rtl/uart_os_rx_fifo.sv
// First-word-fall-through receive FIFO; head entry visible whenever non-empty, zero when empty.
module uart_os_rx_fifo #(
  parameter int width = 12,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_r [depth];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             full_s;
  logic             pop_s;
  logic             push_s;

  // Pointer compare, pop-before-push arbitration and head selection
  always_comb begin
    empty  = (wr_ptr_r == rd_ptr_r);
    full_s = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s  = pop && !empty;
    push_s = push && (!full_s || pop_s);
    drop   = push && full_s && !pop_s;
    if (empty) begin
      rdata = '0;
    end else begin
      rdata = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_os_rx.sv
// 16x oversampling UART receiver: synchronizer, tick generator, majority-vote FSM,
// per-frame error flags and a small FWFT receive FIFO.
module uart_os_rx
  import uart_os_pkg::*;
#(
  parameter int sys_clk    = 40000000,
  parameter int baud_rate  = 9600,
  parameter int data_width = 8,
  parameter int fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  parity_en,
  input  logic                  odd_r_even_parity,
  input  logic                  rd_en,
  output logic [data_width-1:0] data_out,
  output logic                  valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  break_detect,
  output logic                  overrun,
  output logic                  busy
);

  localparam int DIV_RAW = sys_clk / (baud_rate * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(data_width - 1);

  logic                  sync1_r, rx_sync_r, rx_prev_r;
  state_t                state_r;
  logic [CW-1:0]         tick_cnt_r;
  logic [3:0]            samp_r;
  logic [3:0]            bit_cnt_r;
  logic [data_width-1:0] shift_r;
  logic                  v_lo_r, v_mid_r;
  logic                  pbit_r, perr_r;
  logic                  par_en_r, odd_r;
  logic                  overrun_r;

  logic      tick_s, vote_s, decide_s, advance_s, commit_s;
  logic      fifo_empty_s, fifo_drop_s;
  rx_entry_t entry_s, head_s;
  logic      unused_head_s;

  // Tick/sample decode and the entry assembled at the stop-bit decision
  always_comb begin
    tick_s    = (state_r != IDLE) && (tick_cnt_r == TICK_LAST);
    vote_s    = majority3(v_lo_r, v_mid_r, rx_sync_r);
    decide_s  = tick_s && (samp_r == VOTE_HI);
    advance_s = tick_s && (samp_r == BIT_END);
    commit_s  = decide_s && (state_r == STOP);
    entry_s      = '0;
    entry_s.data = DATA_MAX'(shift_r);
    entry_s.perr = perr_r;
    entry_s.ferr = ~vote_s;
    entry_s.brk  = ~vote_s & (shift_r == '0) & (~par_en_r | ~pbit_r);
  end

  // Synchronizer and edge-detect flops idle high so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r   <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= rx;
      rx_sync_r <= sync1_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receive FSM with tick counter, vote capture and frame configuration latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      tick_cnt_r <= '0;
      samp_r     <= 4'd0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= '0;
      v_lo_r     <= 1'b0;
      v_mid_r    <= 1'b0;
      pbit_r     <= 1'b0;
      perr_r     <= 1'b0;
      par_en_r   <= 1'b0;
      odd_r      <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      overrun_r <= commit_s && fifo_drop_s;

      if (state_r == IDLE || tick_s) tick_cnt_r <= '0;
      else                           tick_cnt_r <= tick_cnt_r + CW'(1);

      if (tick_s) begin
        samp_r <= samp_r + 4'd1;
        if (samp_r == VOTE_LO)  v_lo_r  <= rx_sync_r;
        if (samp_r == VOTE_MID) v_mid_r <= rx_sync_r;
      end

      case (state_r)
        IDLE: begin
          if (rx_prev_r && !rx_sync_r) begin
            state_r   <= START;
            samp_r    <= 4'd0;
            bit_cnt_r <= 4'd0;
            par_en_r  <= parity_en;
            odd_r     <= odd_r_even_parity;
            perr_r    <= 1'b0;
            pbit_r    <= 1'b0;
          end
        end
        START: begin
          if (decide_s && vote_s) state_r <= IDLE;
          else if (advance_s)     state_r <= DATA;
        end
        DATA: begin
          if (decide_s) shift_r <= {vote_s, shift_r[data_width-1:1]};
          if (advance_s) begin
            if (bit_cnt_r == LAST_BIT) state_r <= par_en_r ? PARITY : STOP;
            else                       bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        PARITY: begin
          if (decide_s) begin
            pbit_r <= vote_s;
            perr_r <= parity_mismatch(DATA_MAX'(shift_r), vote_s, odd_r);
          end
          if (advance_s) state_r <= STOP;
        end
        // Return to IDLE at the decision point so a back-to-back start edge is seen
        STOP: begin
          if (decide_s) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  uart_os_rx_fifo #(
    .width ($bits(rx_entry_t)),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (commit_s),
    .wdata (entry_s),
    .pop   (rd_en),
    .rdata (head_s),
    .empty (fifo_empty_s),
    .drop  (fifo_drop_s)
  );

  assign unused_head_s = ^head_s.data;
  assign data_out      = head_s.data[data_width-1:0];
  assign valid         = ~fifo_empty_s;
  assign parity_error  = head_s.perr;
  assign framing_error = head_s.ferr;
  assign break_detect  = head_s.brk;
  assign overrun       = overrun_r;
  assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_uart_os_rx.sv
// Directed bench for uart_os_rx: frames are driven bit-by-bit, expected words queued
// at send time and compared when they reach the FIFO head.
module tb_uart_os_rx;

  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_r_even_parity = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       valid, parity_error, framing_error, break_detect, overrun, busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ovr_cnt = 0;
  int   ovr_base;

  uart_os_rx #(
    .sys_clk    (1536000),
    .baud_rate  (9600),
    .data_width (8),
    .fifo_depth (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx                (rx),
    .parity_en         (parity_en),
    .odd_r_even_parity (odd_r_even_parity),
    .rd_en             (rd_en),
    .data_out          (data_out),
    .valid             (valid),
    .parity_error      (parity_error),
    .framing_error     (framing_error),
    .break_detect      (break_detect),
    .overrun           (overrun),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Count overrun pulses
  always @(posedge clk) begin
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    cyc(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_bit,
                            input bit store);
    exp_t e;
    e.data = d;
    e.perr = parity_en ? (((^d) ^ pbit) != odd_r_even_parity) : 1'b0;
    e.ferr = ~stop_bit;
    e.brk  = e.ferr && (d == 8'h00) && (!parity_en || !pbit);
    if (store) sb_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (parity_en) send_bit(pbit);
    send_bit(stop_bit);
  endtask

  task automatic expect_head(input string tag);
    exp_t e;
    for (int i = 0; i < 2000 && valid !== 1'b1; i++) cyc(1);
    chk({tag, "_valid"}, valid, 1);
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL %s_sb observed=empty_queue expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_data"}, data_out, e.data);
      chk({tag, "_perr"}, parity_error, e.perr);
      chk({tag, "_ferr"}, framing_error, e.ferr);
      chk({tag, "_brk"}, break_detect, e.brk);
    end
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_perr", parity_error, 0);
    chk("rst_ferr", framing_error, 0);
    chk("rst_brk", break_detect, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    cyc(20);

    // Plain frame, then pop empties the FIFO
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    expect_head("a5");
    chk("a5_pop_valid", valid, 0);

    // Odd parity, good then bad parity bit
    parity_en = 1'b1;
    odd_r_even_parity = 1'b1;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    expect_head("par_ok");
    send_frame(8'h03, 1'b0, 1'b1, 1'b1);
    expect_head("par_bad");
    parity_en = 1'b0;
    odd_r_even_parity = 1'b0;
    cyc(BIT_CLKS);

    // Short low glitch is rejected at the start-bit vote
    rx = 1'b0;
    cyc(50);
    chk("glitch_busy_hi", busy, 1);
    cyc(30);
    rx = 1'b1;
    cyc(40);
    chk("glitch_busy_lo", busy, 0);
    cyc(200);
    chk("glitch_no_write", valid, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    expect_head("after_glitch");

    // Break: line low for 12 bit times yields exactly one entry
    sb_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    rx = 1'b0;
    cyc(11 * BIT_CLKS);
    chk("brk_no_rearm", busy, 0);
    expect_head("brk");
    cyc(BIT_CLKS - 1);
    rx = 1'b1;
    cyc(2 * BIT_CLKS);
    chk("brk_single", valid, 0);
    chk("brk_idle", busy, 0);

    // Five back-to-back frames into a 4-deep FIFO
    ovr_base = ovr_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 1'b0, 1'b1, i <= 4);
    cyc(5);
    chk("ovr_pulses", ovr_cnt - ovr_base, 1);
    chk("ovr_low", overrun, 0);
    for (int i = 0; i < 4; i++) expect_head("drain");
    chk("drain_empty", valid, 0);

    // Reset in the middle of a frame flushes FIFO and partial data
    send_frame(8'h66, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_valid", valid, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    cyc(40);
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mrst_data", data_out, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ferr", framing_error, 0);
    chk("mrst_ovr", overrun, 0);
    cyc(5);
    rx = 1'b1;
    rst = 1'b1;
    cyc(2 * BIT_CLKS);
    chk("post_rst_valid", valid, 0);
    chk("post_rst_busy", busy, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    expect_head("post_rst");
    chk("post_rst_empty", valid, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
